// File: rtl/memory_rsp_model_pkg.sv
// Shared types and constants for the memory response model: back-pressure modes,
// LFSR constants, stall thresholds and event-counter indices.
package memory_rsp_model_pkg;

   typedef enum logic [1:0] {
      BP_NEVER  = 2'd0,
      BP_LIGHT  = 2'd1,
      BP_MEDIUM = 2'd2,
      BP_HEAVY  = 2'd3
   } bp_t;

   localparam logic [15:0] MRM_LFSR_POLY      = 16'hB400;
   localparam logic [15:0] MRM_LFSR_SEED_STEP = 16'h9E37;

   localparam logic [4:0] MRM_THR_LIGHT  = 5'd5;
   localparam logic [4:0] MRM_THR_MEDIUM = 5'd11;
   localparam logic [4:0] MRM_THR_HEAVY  = 5'd12;

   localparam int unsigned MRM_NB_EV     = 6;
   localparam int unsigned MRM_EV_RD_REQ = 0;
   localparam int unsigned MRM_EV_WR_REQ = 1;
   localparam int unsigned MRM_EV_AMO    = 2;
   localparam int unsigned MRM_EV_RD_RSP = 3;
   localparam int unsigned MRM_EV_WR_RSP = 4;
   localparam int unsigned MRM_EV_STALL  = 5;

   // A 4-bit LFSR sample below this threshold means "stall".
   function automatic logic [4:0] mrm_bp_threshold(input bp_t mode);
      logic [4:0] thr;
      case (mode)
         BP_LIGHT:  thr = MRM_THR_LIGHT;
         BP_MEDIUM: thr = MRM_THR_MEDIUM;
         BP_HEAVY:  thr = MRM_THR_HEAVY;
         default:   thr = 5'd0;
      endcase
      return thr;
   endfunction

   function automatic logic [15:0] mrm_lfsr_seed(input logic [15:0] base, input int unsigned ch);
      logic [15:0] s;
      s = base ^ 16'(ch * 32'(MRM_LFSR_SEED_STEP));
      if (s == 16'h0000) s = 16'h0001;
      return s;
   endfunction

endpackage

// File: rtl/mrm_bp_lfsr.sv
// Single-channel back-pressure generator: Galois LFSR, mode threshold compare
// and a starvation guard bounding consecutive stall cycles.
module mrm_bp_lfsr
   import memory_rsp_model_pkg::*;
#(
   parameter int unsigned MAX_STALL = 16,
   parameter logic [15:0] SEED      = 16'h0001
) (
   input  logic clk,
   input  logic rst,
   input  bp_t  bp_cfg,
   output logic ready_bp
);

   localparam int unsigned RUN_W = $clog2(MAX_STALL + 1);

   logic [15:0]      lfsr_q, lfsr_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             ready_d;

   // The run counter includes the current output cycle; reaching MAX_STALL forces a ready.
   always_comb begin
      lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? MRM_LFSR_POLY : 16'h0000);
      ready_d = ({1'b0, lfsr_q[3:0]} >= mrm_bp_threshold(bp_cfg));
      run_d   = ready_bp ? '0 : run_q + RUN_W'(1);
      if (run_d == RUN_W'(MAX_STALL)) begin
         ready_d = 1'b1;
         run_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q   <= SEED;
         run_q    <= '0;
         ready_bp <= 1'b0;
      end else begin
         lfsr_q   <= lfsr_d;
         run_q    <= run_d;
         ready_bp <= ready_d;
      end
   end

endmodule

// File: rtl/memory_response_bp_counter.sv
// Multi-channel back-pressure generator and handshake bookkeeper: saturating event
// counters, read/write outstanding-depth trackers and a sticky error flag per channel.
module memory_response_bp_counter
   import memory_rsp_model_pkg::*;
#(
   parameter int unsigned NB_CH       = 4,
   parameter int unsigned CNT_WIDTH   = 32,
   parameter int unsigned OUTST_WIDTH = 8,
   parameter int unsigned MAX_STALL   = 16,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [2*NB_CH-1:0]           bp_cfg_i,
   input  logic                         cnt_clr_i,
   input  logic [NB_CH-1:0]             req_valid_i,
   input  logic [NB_CH-1:0]             req_ready_i,
   input  logic [NB_CH-1:0]             req_wrn_i,
   input  logic [NB_CH-1:0]             req_amo_i,
   input  logic [NB_CH-1:0]             rd_res_valid_i,
   input  logic [NB_CH-1:0]             rd_res_ready_i,
   input  logic [NB_CH-1:0]             wr_res_valid_i,
   input  logic [NB_CH-1:0]             wr_res_ready_i,
   output logic [NB_CH-1:0]             req_ready_bp_o,
   output logic [NB_CH*CNT_WIDTH-1:0]   rd_req_cnt_o,
   output logic [NB_CH*CNT_WIDTH-1:0]   wr_req_cnt_o,
   output logic [NB_CH*CNT_WIDTH-1:0]   amo_req_cnt_o,
   output logic [NB_CH*CNT_WIDTH-1:0]   rd_rsp_cnt_o,
   output logic [NB_CH*CNT_WIDTH-1:0]   wr_rsp_cnt_o,
   output logic [NB_CH*CNT_WIDTH-1:0]   stall_cnt_o,
   output logic [NB_CH*OUTST_WIDTH-1:0] rd_outst_o,
   output logic [NB_CH*OUTST_WIDTH-1:0] wr_outst_o,
   output logic [NB_CH-1:0]             err_o
);

   // Returns {error, next depth}; simultaneous inc and dec cancel without error.
   function automatic logic [OUTST_WIDTH:0] outst_step(input logic [OUTST_WIDTH-1:0] cur,
                                                       input logic inc, input logic dec);
      logic [OUTST_WIDTH:0] res;
      res = {1'b0, cur};
      if (inc && !dec) begin
         if (cur == '1) res[OUTST_WIDTH] = 1'b1;
         else           res = {1'b0, cur + OUTST_WIDTH'(1)};
      end else if (dec && !inc) begin
         if (cur == '0) res[OUTST_WIDTH] = 1'b1;
         else           res = {1'b0, cur - OUTST_WIDTH'(1)};
      end
      return res;
   endfunction

   for (genvar c = 0; c < NB_CH; c++) begin : gen_ch
      logic [MRM_NB_EV-1:0] ev;
      logic [CNT_WIDTH-1:0] cnt_q [MRM_NB_EV];
      logic [OUTST_WIDTH-1:0] rd_outst_q, wr_outst_q;
      logic [OUTST_WIDTH:0]   rd_step, wr_step;
      logic                   req_hs, err_q;

      mrm_bp_lfsr #(
         .MAX_STALL (MAX_STALL),
         .SEED      (mrm_lfsr_seed(LFSR_SEED, c))
      ) u_bp (
         .clk      (clk),
         .rst      (rst),
         .bp_cfg   (bp_t'(bp_cfg_i[2*c +: 2])),
         .ready_bp (req_ready_bp_o[c])
      );

      assign req_hs               = req_valid_i[c] & req_ready_i[c];
      assign ev[MRM_EV_RD_REQ]    = req_hs & req_wrn_i[c] & ~req_amo_i[c];
      assign ev[MRM_EV_WR_REQ]    = req_hs & ~req_wrn_i[c] & ~req_amo_i[c];
      assign ev[MRM_EV_AMO]       = req_hs & req_amo_i[c];
      assign ev[MRM_EV_RD_RSP]    = rd_res_valid_i[c] & rd_res_ready_i[c];
      assign ev[MRM_EV_WR_RSP]    = wr_res_valid_i[c] & wr_res_ready_i[c];
      assign ev[MRM_EV_STALL]     = req_valid_i[c] & ~req_ready_i[c];

      // AMO responses come back on the read channel, so AMOs occupy read depth.
      assign rd_step = outst_step(rd_outst_q, ev[MRM_EV_RD_REQ] | ev[MRM_EV_AMO], ev[MRM_EV_RD_RSP]);
      assign wr_step = outst_step(wr_outst_q, ev[MRM_EV_WR_REQ], ev[MRM_EV_WR_RSP]);

      always_ff @(posedge clk) begin
         for (int k = 0; k < MRM_NB_EV; k++) begin
            if (rst || cnt_clr_i)
               cnt_q[k] <= '0;
            else if (ev[k] && cnt_q[k] != '1)
               cnt_q[k] <= cnt_q[k] + CNT_WIDTH'(1);
         end
      end

      // Depth survives a counter clear; only reset discards it.
      always_ff @(posedge clk) begin
         if (rst) begin
            rd_outst_q <= '0;
            wr_outst_q <= '0;
            err_q      <= 1'b0;
         end else begin
            rd_outst_q <= rd_step[OUTST_WIDTH-1:0];
            wr_outst_q <= wr_step[OUTST_WIDTH-1:0];
            if (cnt_clr_i)
               err_q <= 1'b0;
            else if (rd_step[OUTST_WIDTH] || wr_step[OUTST_WIDTH])
               err_q <= 1'b1;
         end
      end

      assign rd_req_cnt_o [c*CNT_WIDTH +: CNT_WIDTH]     = cnt_q[MRM_EV_RD_REQ];
      assign wr_req_cnt_o [c*CNT_WIDTH +: CNT_WIDTH]     = cnt_q[MRM_EV_WR_REQ];
      assign amo_req_cnt_o[c*CNT_WIDTH +: CNT_WIDTH]     = cnt_q[MRM_EV_AMO];
      assign rd_rsp_cnt_o [c*CNT_WIDTH +: CNT_WIDTH]     = cnt_q[MRM_EV_RD_RSP];
      assign wr_rsp_cnt_o [c*CNT_WIDTH +: CNT_WIDTH]     = cnt_q[MRM_EV_WR_RSP];
      assign stall_cnt_o  [c*CNT_WIDTH +: CNT_WIDTH]     = cnt_q[MRM_EV_STALL];
      assign rd_outst_o   [c*OUTST_WIDTH +: OUTST_WIDTH] = rd_outst_q;
      assign wr_outst_o   [c*OUTST_WIDTH +: OUTST_WIDTH] = wr_outst_q;
      assign err_o[c]                                    = err_q;
   end

endmodule

// File: tb/tb_memory_response_bp_counter.sv
// Randomized and directed bench for memory_response_bp_counter against a
// behavioural model of counters, depth trackers and back-pressure sequences.
module tb_memory_response_bp_counter;

   localparam int NB_CH = 4;
   localparam int CW    = 8;
   localparam int OW    = 4;
   localparam int MS    = 4;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam int CNT_MAX = (1 << CW) - 1;
   localparam int OUT_MAX = (1 << OW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2*NB_CH-1:0] bp_cfg_i = '0;
   logic cnt_clr_i = 1'b0;
   logic [NB_CH-1:0] req_valid_i = '0, req_ready_i = '0, req_wrn_i = '0, req_amo_i = '0;
   logic [NB_CH-1:0] rd_res_valid_i = '0, rd_res_ready_i = '0, wr_res_valid_i = '0, wr_res_ready_i = '0;
   logic [NB_CH-1:0] req_ready_bp_o, err_o;
   logic [NB_CH*CW-1:0] rd_req_cnt_o, wr_req_cnt_o, amo_req_cnt_o, rd_rsp_cnt_o, wr_rsp_cnt_o, stall_cnt_o;
   logic [NB_CH*OW-1:0] rd_outst_o, wr_outst_o;
   logic [NB_CH*CW-1:0] dut_cnt [6];

   int checks = 0;
   int errors = 0;

   int          m_cnt [NB_CH][6];
   int          m_rd [NB_CH];
   int          m_wr [NB_CH];
   bit          m_err [NB_CH];
   logic [15:0] m_lfsr [NB_CH];
   int          m_run [NB_CH];
   bit          m_ready [NB_CH];
   int          thr [4] = '{0, 5, 11, 12};
   string       ev_name [6] = '{"rd_req_cnt", "wr_req_cnt", "amo_req_cnt", "rd_rsp_cnt", "wr_rsp_cnt", "stall_cnt"};
   bit          trace [1000];

   always #5 clk = ~clk;

   memory_response_bp_counter #(
      .NB_CH(NB_CH), .CNT_WIDTH(CW), .OUTST_WIDTH(OW), .MAX_STALL(MS), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .bp_cfg_i(bp_cfg_i), .cnt_clr_i(cnt_clr_i),
      .req_valid_i(req_valid_i), .req_ready_i(req_ready_i), .req_wrn_i(req_wrn_i), .req_amo_i(req_amo_i),
      .rd_res_valid_i(rd_res_valid_i), .rd_res_ready_i(rd_res_ready_i),
      .wr_res_valid_i(wr_res_valid_i), .wr_res_ready_i(wr_res_ready_i),
      .req_ready_bp_o(req_ready_bp_o),
      .rd_req_cnt_o(rd_req_cnt_o), .wr_req_cnt_o(wr_req_cnt_o), .amo_req_cnt_o(amo_req_cnt_o),
      .rd_rsp_cnt_o(rd_rsp_cnt_o), .wr_rsp_cnt_o(wr_rsp_cnt_o), .stall_cnt_o(stall_cnt_o),
      .rd_outst_o(rd_outst_o), .wr_outst_o(wr_outst_o), .err_o(err_o)
   );

   assign dut_cnt[0] = rd_req_cnt_o;
   assign dut_cnt[1] = wr_req_cnt_o;
   assign dut_cnt[2] = amo_req_cnt_o;
   assign dut_cnt[3] = rd_rsp_cnt_o;
   assign dut_cnt[4] = wr_rsp_cnt_o;
   assign dut_cnt[5] = stall_cnt_o;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] seedOf(input int c);
      logic [15:0] s;
      s = SEED ^ 16'((c * 32'h9E37) & 32'hFFFF);
      return (s == 16'h0) ? 16'h0001 : s;
   endfunction

   // Reference behaviour for one rising edge, from the current input values.
   task automatic modelStep();
      bit hs;
      bit ev [6];
      int nrd, nwr;
      for (int c = 0; c < NB_CH; c++) begin
         if (rst) begin
            for (int k = 0; k < 6; k++) m_cnt[c][k] = 0;
            m_rd[c] = 0; m_wr[c] = 0; m_err[c] = 0;
            m_lfsr[c] = seedOf(c); m_run[c] = 0; m_ready[c] = 0;
         end else begin
            bit nxt;
            nxt = (int'(m_lfsr[c] & 16'hF) >= thr[bp_cfg_i[2*c +: 2]]);
            m_run[c] = m_ready[c] ? 0 : m_run[c] + 1;
            if (m_run[c] == MS) begin nxt = 1; m_run[c] = 0; end
            m_lfsr[c] = (m_lfsr[c] >> 1) ^ (m_lfsr[c][0] ? 16'hB400 : 16'h0000);
            m_ready[c] = nxt;

            hs = req_valid_i[c] && req_ready_i[c];
            ev[0] = hs && req_wrn_i[c] && !req_amo_i[c];
            ev[1] = hs && !req_wrn_i[c] && !req_amo_i[c];
            ev[2] = hs && req_amo_i[c];
            ev[3] = rd_res_valid_i[c] && rd_res_ready_i[c];
            ev[4] = wr_res_valid_i[c] && wr_res_ready_i[c];
            ev[5] = req_valid_i[c] && !req_ready_i[c];
            if (cnt_clr_i) begin
               for (int k = 0; k < 6; k++) m_cnt[c][k] = 0;
               m_err[c] = 0;
            end else begin
               for (int k = 0; k < 6; k++)
                  if (ev[k] && m_cnt[c][k] < CNT_MAX) m_cnt[c][k]++;
            end
            nrd = m_rd[c] + int'(ev[0] || ev[2]) - int'(ev[3]);
            nwr = m_wr[c] + int'(ev[1]) - int'(ev[4]);
            if (nrd < 0 || nrd > OUT_MAX) begin if (!cnt_clr_i) m_err[c] = 1; end
            else m_rd[c] = nrd;
            if (nwr < 0 || nwr > OUT_MAX) begin if (!cnt_clr_i) m_err[c] = 1; end
            else m_wr[c] = nwr;
         end
      end
   endtask

   task automatic compareAll();
      logic [NB_CH*CW-1:0] ec;
      logic [NB_CH*OW-1:0] er, ew;
      logic [NB_CH-1:0]    ee, eb;
      for (int k = 0; k < 6; k++) begin
         ec = '0;
         for (int c = 0; c < NB_CH; c++) ec[c*CW +: CW] = CW'(m_cnt[c][k]);
         checkOutput(ev_name[k], dut_cnt[k], ec);
      end
      er = '0; ew = '0; ee = '0; eb = '0;
      for (int c = 0; c < NB_CH; c++) begin
         er[c*OW +: OW] = OW'(m_rd[c]);
         ew[c*OW +: OW] = OW'(m_wr[c]);
         ee[c] = m_err[c];
         eb[c] = m_ready[c];
      end
      checkOutput("rd_outst", rd_outst_o, er);
      checkOutput("wr_outst", wr_outst_o, ew);
      checkOutput("err", err_o, ee);
      checkOutput("req_ready_bp", req_ready_bp_o, eb);
   endtask

   // One clock: inputs were set at the preceding falling edge.
   task automatic applyStimulus();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      compareAll();
   endtask

   task automatic clearInputs();
      cnt_clr_i = 0;
      req_valid_i = '0; req_ready_i = '0; req_wrn_i = '0; req_amo_i = '0;
      rd_res_valid_i = '0; rd_res_ready_i = '0; wr_res_valid_i = '0; wr_res_ready_i = '0;
   endtask

   task automatic doReset(input int cycles);
      clearInputs();
      rst = 1;
      for (int i = 0; i < cycles; i++) applyStimulus();
      rst = 0;
   endtask

   initial begin
      int max_run, cur_run, stalls, diffs;
      @(negedge clk);
      doReset(3);
      checkOutput("reset_ready_bp", req_ready_bp_o, 4'h0);
      checkOutput("reset_rd_outst", rd_outst_o, '0);

      // NEVER everywhere, 10 reads on ch0
      bp_cfg_i = '0;
      for (int i = 0; i < 10; i++) begin
         req_valid_i[0] = 1; req_ready_i[0] = 1; req_wrn_i[0] = 1;
         applyStimulus();
         checkOutput("never_ready_all", req_ready_bp_o, 4'hF);
      end
      clearInputs();
      checkOutput("ch0_rd_req_10", rd_req_cnt_o[0 +: CW], 8'd10);
      checkOutput("ch0_rd_outst_10", rd_outst_o[0 +: OW], 4'd10);

      // ch2: one write, three reads, then cancelling pairs
      req_valid_i[2] = 1; req_ready_i[2] = 1; req_wrn_i[2] = 0;
      applyStimulus();
      req_wrn_i[2] = 1;
      for (int i = 0; i < 3; i++) applyStimulus();
      rd_res_valid_i[2] = 1; rd_res_ready_i[2] = 1;
      applyStimulus();
      checkOutput("ch2_net_zero_rd_outst", rd_outst_o[2*OW +: OW], 4'd3);
      checkOutput("ch2_net_zero_err", err_o[2], 1'b0);
      clearInputs();
      rd_res_valid_i[2] = 1; rd_res_ready_i[2] = 1; wr_res_valid_i[2] = 1; wr_res_ready_i[2] = 1;
      applyStimulus();
      clearInputs();
      checkOutput("ch2_rd_outst_2", rd_outst_o[2*OW +: OW], 4'd2);
      checkOutput("ch2_rd_rsp_2", rd_rsp_cnt_o[2*CW +: CW], 8'd2);
      checkOutput("ch2_wr_rsp_1", wr_rsp_cnt_o[2*CW +: CW], 8'd1);

      // ch3: write-response underflow, sticky error, then clear
      wr_res_valid_i[3] = 1; wr_res_ready_i[3] = 1;
      applyStimulus();
      clearInputs();
      checkOutput("ch3_wr_outst_0", wr_outst_o[3*OW +: OW], 4'd0);
      checkOutput("ch3_err_set", err_o[3], 1'b1);
      req_valid_i[3] = 1; req_ready_i[3] = 1; req_wrn_i[3] = 1;
      for (int i = 0; i < 2; i++) applyStimulus();
      clearInputs();
      applyStimulus();
      checkOutput("ch3_err_held", err_o[3], 1'b1);
      cnt_clr_i = 1;
      applyStimulus();
      clearInputs();
      checkOutput("clr_err", err_o, 4'h0);
      checkOutput("clr_rd_req_cnt", rd_req_cnt_o, '0);
      checkOutput("clr_keeps_ch3_rd_outst", rd_outst_o[3*OW +: OW], 4'd2);
      checkOutput("clr_keeps_ch0_rd_outst", rd_outst_o[0 +: OW], 4'd10);

      // reset mid-operation, then AMO on ch0
      doReset(2);
      req_valid_i[0] = 1; req_ready_i[0] = 1; req_wrn_i[0] = 1; req_amo_i[0] = 1;
      applyStimulus();
      clearInputs();
      checkOutput("amo_cnt_1", amo_req_cnt_o[0 +: CW], 8'd1);
      checkOutput("amo_rd_req_0", rd_req_cnt_o[0 +: CW], 8'd0);
      checkOutput("amo_rd_outst_1", rd_outst_o[0 +: OW], 4'd1);
      rd_res_valid_i[0] = 1; rd_res_ready_i[0] = 1;
      applyStimulus();
      clearInputs();
      checkOutput("amo_rd_outst_0", rd_outst_o[0 +: OW], 4'd0);

      // counter saturation
      req_valid_i[0] = 1; req_ready_i[0] = 1; req_wrn_i[0] = 1;
      for (int i = 0; i < CNT_MAX + 3; i++) applyStimulus();
      clearInputs();
      checkOutput("rd_req_saturated", rd_req_cnt_o[0 +: CW], CNT_MAX);
      checkOutput("rd_outst_overflow_err", err_o[0], 1'b1);

      // HEAVY on ch1 with random traffic everywhere
      for (int c = 0; c < NB_CH; c++) bp_cfg_i[2*c +: 2] = 2'($urandom_range(0, 3));
      bp_cfg_i[3:2] = 2'd3;
      doReset(2);
      max_run = 0; cur_run = 0; stalls = 0;
      for (int i = 0; i < 1000; i++) begin
         clearInputs();
         if ($urandom_range(0, 49) == 0) cnt_clr_i = 1;
         else begin
            for (int c = 0; c < NB_CH; c++) begin
               req_valid_i[c]    = 1'($urandom_range(0, 1));
               req_ready_i[c]    = 1'($urandom_range(0, 1));
               req_wrn_i[c]      = 1'($urandom_range(0, 1));
               req_amo_i[c]      = ($urandom_range(0, 3) == 0);
               rd_res_valid_i[c] = 1'($urandom_range(0, 1));
               rd_res_ready_i[c] = ($urandom_range(0, 3) != 0);
               wr_res_valid_i[c] = 1'($urandom_range(0, 1));
               wr_res_ready_i[c] = ($urandom_range(0, 3) != 0);
            end
         end
         if ($urandom_range(0, 99) == 0) begin
            bp_cfg_i[1:0] = 2'($urandom_range(0, 3));
            bp_cfg_i[7:4] = 4'($urandom_range(0, 15));
         end
         applyStimulus();
         trace[i] = req_ready_bp_o[1];
         if (!req_ready_bp_o[1]) begin
            stalls++; cur_run++;
            if (cur_run > max_run) max_run = cur_run;
         end else cur_run = 0;
      end
      clearInputs();
      checkOutput("ch1_max_stall_run_bounded", (max_run <= MS), 1);
      $display("[TB] ch1 HEAVY stall cycles %0d of 1000, longest run %0d", stalls, max_run);

      // same seed and mode, different traffic: ch1 sequence must repeat
      doReset(2);
      diffs = 0;
      for (int i = 0; i < 1000; i++) begin
         applyStimulus();
         if (req_ready_bp_o[1] !== trace[i]) diffs++;
      end
      checkOutput("ch1_rerun_trace_diffs", diffs, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
